// File: rtl/module3_fine_sync_pkg.sv
// Shared constants, state encoding and magnitude helpers for the 72s/36s sequential divider.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package module3_fine_sync_pkg;

    localparam int DIN0_W  = 72;
    localparam int DIN1_W  = 36;
    localparam int DOUT_W  = 36;
    localparam int ITER    = 36;
    localparam int LATENCY = 38;
    localparam int CNT_W   = 6;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_FIX,
        ST_DONE
    } state_t;

    // Magnitudes are returned unsigned, so the most negative operand maps to 2^(W-1) without wrapping.
    function automatic logic [DIN0_W-1:0] mag_din0(input logic [DIN0_W-1:0] x);
        return x[DIN0_W-1] ? ((~x) + DIN0_W'(1)) : x;
    endfunction

    function automatic logic [DIN1_W-1:0] mag_din1(input logic [DIN1_W-1:0] x);
        return x[DIN1_W-1] ? ((~x) + DIN1_W'(1)) : x;
    endfunction

endpackage

// File: rtl/module3_fine_sync_sdiv_sat.sv
// Applies signs to quotient/remainder magnitudes and saturates the quotient to 36-bit signed.
// Latency: combinational.
// Backpressure: none.
module module3_fine_sync_sdiv_sat
    import module3_fine_sync_pkg::*;
(
    input  logic [DOUT_W-1:0] qmag,
    input  logic [DOUT_W-1:0] rmag,
    input  logic              q_neg,
    input  logic              a_neg,
    input  logic              ovf_pre,
    input  logic              dz_in,
    output logic [DOUT_W-1:0] q,
    output logic [DOUT_W-1:0] r,
    output logic              ovf
);

    localparam logic [DOUT_W-1:0] Q_MAX = {1'b0, {(DOUT_W-1){1'b1}}};
    localparam logic [DOUT_W-1:0] Q_MIN = {1'b1, {(DOUT_W-1){1'b0}}};

    logic pos_sat;
    logic neg_sat;

    always_comb begin
        pos_sat = ~q_neg & qmag[DOUT_W-1];
        neg_sat = q_neg & qmag[DOUT_W-1] & (|qmag[DOUT_W-2:0]);
        q       = q_neg ? ((~qmag) + DOUT_W'(1)) : qmag;
        r       = a_neg ? ((~rmag) + DOUT_W'(1)) : rmag;
        ovf     = 1'b0;
        if (dz_in) begin
            q = a_neg ? Q_MIN : Q_MAX;
            r = '0;
        end else if (ovf_pre || pos_sat || neg_sat) begin
            q   = q_neg ? Q_MIN : Q_MAX;
            ovf = 1'b1;
            // With ovf_pre the iteration never held a valid partial remainder.
            if (ovf_pre) begin
                r = '0;
            end
        end
    end

endmodule

// File: rtl/module3_fine_sync_sdiv_72s_36s_36_seq.sv
// Signed 72/36 restoring divider: truncating quotient with saturation, remainder follows dividend sign.
// Latency: fixed 38 cycles accept-to-ap_done, next accept one cycle after ap_done.
// Backpressure: ap_start is only sampled while idle; requests while busy are dropped.
module module3_fine_sync_sdiv_72s_36s_36_seq
    import module3_fine_sync_pkg::*;
#(
    parameter int ID         = 1,
    parameter int NUM_STAGE  = 38,
    parameter int din0_WIDTH = 72,
    parameter int din1_WIDTH = 36,
    parameter int dout_WIDTH = 36
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  ap_start,
    output logic                  ap_done,
    output logic                  ap_idle,
    output logic                  ap_ready,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic [dout_WIDTH-1:0] dout,
    output logic [dout_WIDTH-1:0] dout_rem,
    output logic                  ovf,
    output logic                  dz
);

    // ID and NUM_STAGE are descriptive; the schedule below is always LATENCY cycles.
    if (NUM_STAGE != LATENCY || ID < 0) begin : g_stage_param_mismatch
    end

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [DOUT_W-1:0]  rem;
    logic [DOUT_W-1:0]  lo;
    logic [DIN1_W-1:0]  dmag;
    logic               a_neg;
    logic               q_neg;
    logic               ovf_pre;
    logic               dz_pre;

    logic [DIN0_W-1:0]  amag_in;
    logic [DIN1_W-1:0]  dmag_in;
    logic [DOUT_W:0]    sh;
    logic [DOUT_W+1:0]  sub;
    logic               ge;
    logic [DOUT_W-1:0]  rem_nxt;

    logic [DOUT_W-1:0]  sat_q;
    logic [DOUT_W-1:0]  sat_r;
    logic               sat_ovf;

    assign amag_in = mag_din0(din0);
    assign dmag_in = mag_din1(din1);

    // lo starts as the dividend low half and fills with quotient bits as it shifts out.
    assign sh  = {rem, lo[DOUT_W-1]};
    assign sub = {1'b0, sh} - {2'b00, dmag};
    // The pre-shift remainder is below the divisor, so a non-negative difference leaves bit 36 clear.
    assign ge      = ~(sub[DOUT_W+1] | sub[DOUT_W]);
    assign rem_nxt = ge ? sub[DOUT_W-1:0] : sh[DOUT_W-1:0];

    module3_fine_sync_sdiv_sat u_sat (
        .qmag    (lo),
        .rmag    (rem),
        .q_neg   (q_neg),
        .a_neg   (a_neg),
        .ovf_pre (ovf_pre),
        .dz_in   (dz_pre),
        .q       (sat_q),
        .r       (sat_r),
        .ovf     (sat_ovf)
    );

    assign ap_ready = ap_done;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            rem      <= '0;
            lo       <= '0;
            dmag     <= '0;
            a_neg    <= 1'b0;
            q_neg    <= 1'b0;
            ovf_pre  <= 1'b0;
            dz_pre   <= 1'b0;
            dout     <= '0;
            dout_rem <= '0;
            ovf      <= 1'b0;
            dz       <= 1'b0;
            ap_done  <= 1'b0;
            ap_idle  <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    ap_done <= 1'b0;
                    if (ap_start) begin
                        rem     <= amag_in[DIN0_W-1:DOUT_W];
                        lo      <= amag_in[DOUT_W-1:0];
                        dmag    <= dmag_in;
                        a_neg   <= din0[DIN0_W-1];
                        q_neg   <= din0[DIN0_W-1] ^ din1[DIN1_W-1];
                        ovf_pre <= (amag_in[DIN0_W-1:DOUT_W] >= dmag_in);
                        dz_pre  <= (din1 == '0);
                        cnt     <= '0;
                        ap_idle <= 1'b0;
                        state   <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    rem <= rem_nxt;
                    lo  <= {lo[DOUT_W-2:0], ge};
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(ITER - 1)) begin
                        state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    dout     <= sat_q;
                    dout_rem <= sat_r;
                    ovf      <= sat_ovf;
                    dz       <= dz_pre;
                    ap_done  <= 1'b1;
                    state    <= ST_DONE;
                end
                ST_DONE: begin
                    ap_done <= 1'b0;
                    ap_idle <= 1'b1;
                    state   <= ST_IDLE;
                end
                default: begin
                    ap_done <= 1'b0;
                    ap_idle <= 1'b1;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_module3_fine_sync_sdiv_72s_36s_36_seq.sv
// Scoreboarded bench: expectations queued at accept, compared in the cycle ap_done is due.
module tb_module3_fine_sync_sdiv_72s_36s_36_seq;

    localparam logic [35:0] MAXQ = 36'h7FFFFFFFF;
    localparam logic [35:0] MINQ = 36'h800000000;

    typedef struct packed {
        logic [35:0] q;
        logic [35:0] r;
        logic        ovf;
        logic        dz;
        logic        chk_r;
    } exp_t;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n;
    logic        ap_start;
    logic        ap_done;
    logic        ap_idle;
    logic        ap_ready;
    logic [71:0] din0;
    logic [35:0] din1;
    logic [35:0] dout;
    logic [35:0] dout_rem;
    logic        ovf;
    logic        dz;

    int   errors   = 0;
    int   checks   = 0;
    int   cyc      = 0;
    int   next_ok  = 0;
    int   n_accept = 0;
    exp_t next_exp;
    exp_t cur;
    logic exp_done;
    exp_t exp_q[$];
    int   cyc_q[$];

    module3_fine_sync_sdiv_72s_36s_36_seq #(
        .ID(1), .NUM_STAGE(38), .din0_WIDTH(72), .din1_WIDTH(36), .dout_WIDTH(36)
    ) dut (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .ap_start (ap_start),
        .ap_done  (ap_done),
        .ap_idle  (ap_idle),
        .ap_ready (ap_ready),
        .din0     (din0),
        .din1     (din1),
        .dout     (dout),
        .dout_rem (dout_rem),
        .ovf      (ovf),
        .dz       (dz)
    );

    always #5 ap_clk = ~ap_clk;

    always @(posedge ap_clk) cyc++;

    task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] expv);
        checks++;
        assert (got === expv) else begin
            errors++;
            $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, expv);
        end
    endtask

    function automatic exp_t mk(input logic [35:0] q, input logic [35:0] r,
                                input logic o, input logic z, input logic c);
        exp_t e;
        e.q = q; e.r = r; e.ovf = o; e.dz = z; e.chk_r = c;
        return e;
    endfunction

    // Reference: native wide unsigned divide on magnitudes, then sign and clamp.
    function automatic exp_t golden(input logic [71:0] a, input logic [35:0] d);
        exp_t        e;
        logic [71:0] am, dm, qm, rm;
        logic        qn;
        e = mk(36'd0, 36'd0, 1'b0, 1'b0, 1'b1);
        if (d == 36'd0) begin
            e.q  = a[71] ? MINQ : MAXQ;
            e.dz = 1'b1;
            return e;
        end
        am = a[71] ? (72'd0 - a) : a;
        dm = d[35] ? (72'd0 - {{36{1'b1}}, d}) : {36'd0, d};
        qm = am / dm;
        rm = am % dm;
        qn = a[71] ^ d[35];
        if (qm >= (72'd1 << 36)) e.chk_r = 1'b0;
        if (!qn && qm > 72'h7FFFFFFFF) begin
            e.q = MAXQ; e.ovf = 1'b1;
        end else if (qn && qm > 72'h800000000) begin
            e.q = MINQ; e.ovf = 1'b1;
        end else begin
            e.q = qn ? (36'd0 - qm[35:0]) : qm[35:0];
        end
        e.r = a[71] ? (36'd0 - rm[35:0]) : rm[35:0];
        return e;
    endfunction

    always @(negedge ap_clk) begin
        if (!ap_rst_n) begin
            exp_q.delete();
            cyc_q.delete();
            next_ok = cyc;
            chk("rst_dout", dout, 0);
            chk("rst_rem", dout_rem, 0);
            chk("rst_ovf", ovf, 0);
            chk("rst_dz", dz, 0);
            chk("rst_done", ap_done, 0);
            chk("rst_idle", ap_idle, 1);
        end else begin
            exp_done = (cyc_q.size() != 0) && (cyc_q[0] == cyc);
            chk("done", ap_done, exp_done);
            chk("ready", ap_ready, exp_done);
            chk("idle", ap_idle, cyc >= next_ok);
            if (exp_done) begin
                cur = exp_q.pop_front();
                void'(cyc_q.pop_front());
                chk("dout", dout, cur.q);
                if (cur.chk_r) chk("dout_rem", dout_rem, cur.r);
                chk("ovf", ovf, cur.ovf);
                chk("dz", dz, cur.dz);
            end
            if (cyc >= next_ok && ap_start) begin
                exp_q.push_back(next_exp);
                cyc_q.push_back(cyc + 38);
                next_ok = cyc + 39;
                n_accept++;
            end
        end
    end

    task automatic start_op(input logic [71:0] a, input logic [35:0] d, input exp_t e);
        int base;
        base     = n_accept;
        din0     = a;
        din1     = d;
        next_exp = e;
        ap_start = 1'b1;
        for (int i = 0; i < 100 && n_accept == base; i++) @(posedge ap_clk);
        #1;
        chk("accept", n_accept != base, 1);
        ap_start = 1'b0;
        din0     = ~a;
        din1     = ~d;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge ap_clk);
        #1;
        chk("drain", exp_q.size(), 0);
    endtask

    task automatic do_op(input logic [71:0] a, input logic [35:0] d, input exp_t e);
        start_op(a, d, e);
        wait_drain();
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog cyc=%0d errors=%0d", cyc, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [95:0] r96;
        logic [63:0] r64;
        logic [71:0] a;
        logic [35:0] d;
        int          base;

        ap_rst_n = 1'b0;
        ap_start = 1'b0;
        din0     = '0;
        din1     = '0;
        next_exp = '0;
        repeat (3) @(posedge ap_clk);
        #1 ap_rst_n = 1'b1;
        @(posedge ap_clk);
        #1;

        do_op(72'd100, 36'd7, mk(36'd14, 36'd2, 1'b0, 1'b0, 1'b1));
        do_op(72'd0 - 72'd100, 36'd7, mk(36'd0 - 36'd14, 36'd0 - 36'd2, 1'b0, 1'b0, 1'b1));
        do_op(72'd100, 36'd0 - 36'd7, mk(36'd0 - 36'd14, 36'd2, 1'b0, 1'b0, 1'b1));
        do_op(72'd1 << 70, 36'd1, mk(MAXQ, 36'd0, 1'b1, 1'b0, 1'b0));
        do_op(72'd0 - (72'd1 << 35), 36'd1, mk(MINQ, 36'd0, 1'b0, 1'b0, 1'b1));
        do_op(72'd1 << 35, 36'd1, mk(MAXQ, 36'd0, 1'b1, 1'b0, 1'b1));
        do_op(72'd5, 36'd0, mk(MAXQ, 36'd0, 1'b0, 1'b1, 1'b1));
        do_op(72'd0 - 72'd5, 36'd0, mk(MINQ, 36'd0, 1'b0, 1'b1, 1'b1));
        do_op(72'd1 << 71, 36'd1 << 35, mk(MAXQ, 36'd0, 1'b1, 1'b0, 1'b0));
        do_op(72'd1 << 71, 36'd1, mk(MINQ, 36'd0, 1'b1, 1'b0, 1'b0));
        do_op(72'd0 - 72'd7, 36'd100, mk(36'd0, 36'd0 - 36'd7, 1'b0, 1'b0, 1'b1));
        do_op(72'd0 - (72'd7 << 35) - 72'd1, 36'd7, mk(MINQ, 36'd0 - 36'd1, 1'b0, 1'b0, 1'b1));
        do_op(72'd7 << 35, 36'd7, mk(MAXQ, 36'd0, 1'b1, 1'b0, 1'b1));

        // Abort in the 20th CALC cycle; the queued result must never appear.
        start_op(72'd100, 36'd7, mk(36'd14, 36'd2, 1'b0, 1'b0, 1'b1));
        repeat (19) @(posedge ap_clk);
        #1 ap_rst_n = 1'b0;
        repeat (2) @(posedge ap_clk);
        #1 ap_rst_n = 1'b1;
        do_op(72'd100, 36'd7, mk(36'd14, 36'd2, 1'b0, 1'b0, 1'b1));

        ap_start = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            r96 = {$urandom, $urandom, $urandom};
            r64 = {$urandom, $urandom};
            a   = r96[71:0];
            d   = r64[35:0];
            a   = $signed(a) >>> $urandom_range(0, 71);
            d   = $signed(d) >>> $urandom_range(0, 35);
            din0     = a;
            din1     = d;
            next_exp = golden(a, d);
            base     = n_accept;
            for (int i = 0; i < 100 && n_accept == base; i++) @(posedge ap_clk);
            #1;
            chk("rand_accept", n_accept != base, 1);
        end
        ap_start = 1'b0;
        wait_drain();

        repeat (5) @(posedge ap_clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
